// File: rtl/lcd_pkg.sv
// Shared types, constants and address helpers for the HD44780 bus decoder.
package lcd_pkg;

  localparam logic [7:0] M_SET_DDRAM = 8'h80;
  localparam logic [7:0] M_SET_CGRAM = 8'h40;
  localparam logic [7:0] M_FUNC_SET  = 8'h20;
  localparam logic [7:0] M_SHIFT     = 8'h10;
  localparam logic [7:0] M_DISP_CTRL = 8'h08;
  localparam logic [7:0] M_ENTRY     = 8'h04;
  localparam logic [7:0] M_HOME      = 8'h02;
  localparam logic [7:0] M_CLEAR     = 8'h01;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_LAST = 7'h27;
  localparam logic [6:0] LINE2_LAST = 7'h67;

  localparam int         WIN_LEN = 16;
  localparam logic [7:0] BLANK   = 8'h20;

  localparam int ERR_OVF = 0;
  localparam int ERR_RW  = 1;
  localparam int ERR_DL  = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} state_t;

  typedef enum logic [3:0] {
    C_NOP, C_CLEAR, C_HOME, C_ENTRY, C_DISP, C_SHIFT, C_FUNC, C_CGRAM, C_DDRAM
  } cmd_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } slot_t;

  // Highest set bit selects the instruction.
  function automatic cmd_t decode_cmd(input logic [7:0] d);
    if      ((d & M_SET_DDRAM) != 8'h00) return C_DDRAM;
    else if ((d & M_SET_CGRAM) != 8'h00) return C_CGRAM;
    else if ((d & M_FUNC_SET)  != 8'h00) return C_FUNC;
    else if ((d & M_SHIFT)     != 8'h00) return C_SHIFT;
    else if ((d & M_DISP_CTRL) != 8'h00) return C_DISP;
    else if ((d & M_ENTRY)     != 8'h00) return C_ENTRY;
    else if ((d & M_HOME)      != 8'h00) return C_HOME;
    else if ((d & M_CLEAR)     != 8'h00) return C_CLEAR;
    else                                 return C_NOP;
  endfunction

  // The two 40-cell DDRAM lines form one 80-cell ring.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == LINE1_LAST) return LINE2_BASE;
      if (ac == LINE2_LAST) return LINE1_BASE;
      return ac + 7'd1;
    end
    if (ac == LINE1_BASE) return LINE2_LAST;
    if (ac == LINE2_BASE) return LINE1_LAST;
    return ac - 7'd1;
  endfunction

  function automatic logic win_hit(input logic [6:0] ac);
    logic [6:0] off1;
    logic [6:0] off2;
    off1 = ac - LINE1_BASE;
    off2 = ac - LINE2_BASE;
    return (off1 < 7'(WIN_LEN)) || (off2 < 7'(WIN_LEN));
  endfunction

  function automatic logic [4:0] win_idx(input logic [6:0] ac);
    logic [6:0] off2;
    off2 = ac - LINE2_BASE;
    return {off2 < 7'(WIN_LEN), ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Bus synchronizer and EN falling-edge detector; emits one event per write strobe.
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  output logic       ev,
  output logic       ev_rw,
  output logic       ev_rs,
  output logic [7:0] ev_data
);

  logic [10:0] sync_q [SYNC_STAGES];
  logic [10:0] last;
  logic        en_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      en_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {LCD_EN, LCD_RW, LCD_RS, LCD_DATA};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      en_prev_q <= sync_q[SYNC_STAGES-1][10];
    end
  end

  // RW/RS/DATA come from the same stage as EN so they line up with the edge.
  assign last    = sync_q[SYNC_STAGES-1];
  assign ev      = en_prev_q & ~last[10];
  assign ev_rw   = last[9];
  assign ev_rs   = last[8];
  assign ev_data = last[7:0];

endmodule

// File: rtl/lcd_bus_decoder.sv
// Snoops the LCD bus, decodes commands/characters and keeps a 32-cell shadow of the panel.
module lcd_bus_decoder
  import lcd_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CLEAR_FILL  = BLANK
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic [4:0] iRD_ADDR,
  output logic [7:0] oRD_CHAR,
  output logic       oCMD_VALID,
  output logic [7:0] oCMD,
  output logic       oCHAR_VALID,
  output logic       oFRAME_DONE,
  output logic [6:0] oAC,
  output logic [2:0] oDISP_CTRL,
  output logic       oBUSY,
  output logic [2:0] oERR
);

  localparam logic [4:0] LAST_IDX   = 5'(2*WIN_LEN - 1);
  localparam logic [6:0] FRAME_ADDR = LINE2_BASE + 7'(WIN_LEN - 1);

  logic       ev, ev_rw, ev_rs;
  logic [7:0] ev_data;

  state_t     state_q, state_d;
  slot_t      slot_q;
  logic       slot_full_q;
  logic       clr_req_q;
  logic [4:0] clr_idx_q;
  logic       entry_inc_q;
  logic       cgram_q;

  logic [7:0] mem [2*WIN_LEN];
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .LCD_DATA (LCD_DATA),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_RS   (LCD_RS),
    .ev       (ev),
    .ev_rw    (ev_rw),
    .ev_rs    (ev_rs),
    .ev_data  (ev_data)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST_N) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_req_q)        state_d = ST_CLEAR;
                else if (slot_full_q) state_d = ST_EXEC;
      ST_EXEC:  state_d = (!slot_q.rs && decode_cmd(slot_q.data) == C_CLEAR) ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: if (clr_idx_q == LAST_IDX) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    oCMD_VALID  = 1'b0;
    oCHAR_VALID = 1'b0;
    oFRAME_DONE = 1'b0;
    oBUSY       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_idx_q;
    mem_wdata   = CLEAR_FILL;
    case (state_q)
      ST_EXEC: begin
        oCMD_VALID  = !slot_q.rs;
        oCHAR_VALID = slot_q.rs && !cgram_q;
        oFRAME_DONE = oCHAR_VALID && (oAC == FRAME_ADDR);
        mem_we      = oCHAR_VALID && win_hit(oAC);
        mem_waddr   = win_idx(oAC);
        mem_wdata   = slot_q.data;
      end
      ST_CLEAR: begin
        oBUSY  = 1'b1;
        mem_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oAC         <= LINE1_BASE;
      entry_inc_q <= 1'b1;
      cgram_q     <= 1'b0;
      oDISP_CTRL  <= '0;
      oCMD        <= '0;
      oERR        <= '0;
      slot_q      <= '0;
      slot_full_q <= 1'b0;
      clr_req_q   <= 1'b1;
      clr_idx_q   <= '0;
    end else begin
      clr_idx_q <= (state_q == ST_CLEAR) ? clr_idx_q + 5'd1 : 5'd0;
      if (state_q == ST_CLEAR) clr_req_q <= 1'b0;

      // EXEC frees the slot in the same edge a new event may refill it.
      if (state_q == ST_EXEC) slot_full_q <= 1'b0;
      if (ev) begin
        if (ev_rw)
          oERR[ERR_RW] <= 1'b1;
        else if (slot_full_q && state_q != ST_EXEC)
          oERR[ERR_OVF] <= 1'b1;
        else begin
          slot_q      <= '{rs: ev_rs, data: ev_data};
          slot_full_q <= 1'b1;
        end
      end

      case (state_q)
        ST_EXEC: begin
          if (!slot_q.rs) begin
            oCMD <= slot_q.data;
            case (decode_cmd(slot_q.data))
              C_DDRAM: begin
                oAC     <= slot_q.data[6:0];
                cgram_q <= 1'b0;
              end
              C_CGRAM: cgram_q <= 1'b1;
              C_FUNC:  if (!slot_q.data[4]) oERR[ERR_DL] <= 1'b1;
              C_SHIFT: if (!slot_q.data[3]) oAC <= ac_step(oAC, slot_q.data[2]);
              C_DISP:  oDISP_CTRL <= slot_q.data[2:0];
              C_ENTRY: entry_inc_q <= slot_q.data[1];
              C_HOME:  oAC <= LINE1_BASE;
              default: ;
            endcase
          end else if (!cgram_q) begin
            oAC <= ac_step(oAC, entry_inc_q);
          end
        end
        ST_CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            oAC         <= LINE1_BASE;
            entry_inc_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the shadow RAM has no reset; the CLEAR walk initialises it instead.
  always_ff @(posedge iCLK) begin
    if (iRST_N && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) oRD_CHAR <= '0;
    else         oRD_CHAR <= mem[iRD_ADDR];
  end

endmodule
